// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port data memory between the CPU MEM stage and a camera
// pixel writer. The CPU has fixed priority; optionally a starvation counter
// forces a camera grant after STARVE_LIM consecutive lost arbitrations.
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> 3-bit saturating starvation counter active.
//                  undefined -> fixed CPU priority, camera may starve.
//
// Handshakes:
//   cpu_req_i is held by the pipeline until a cycle with cpu_stall_o=0; that
//   cycle completes the store, or for a load hands the result to the
//   following cycle's cpu_rvalid_o pulse. cam_req_i is held until the
//   single-cycle cam_gnt_o pulse, which marks the write cycle itself.
//
// Ports:
//   clk_i, rst_i                   clock, async active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i  CPU access request
//   cpu_stall_o                    freeze IF/ID/EX/MEM registers
//   cpu_rdata_o, cpu_rvalid_o      registered load data + one-cycle valid
//   cam_req_i/addr_i/wdata_i       camera write request
//   cam_gnt_o                      camera write committed this cycle
//   mem_we_o/addr_o/wdata_o        data-memory port
//   mem_rdata_i                    data-memory read data (1-cycle latency)
//   state_o                        FSM state (0 IDLE, 1 CPU_RD, 2 CAM_WR)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic        cpu_stall_o,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_rvalid_o,
  input  logic        cam_req_i,
  input  logic [31:0] cam_addr_i,
  input  logic [31:0] cam_wdata_i,
  output logic        cam_gnt_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    CAM_WR = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cam_addr_q, cam_wdata_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [31:0] cpu_rdata_q;
  logic        cpu_rvalid_q;
  logic        cam_gnt_q;
  logic        cam_force;
  logic        cpu_wins;
  logic        cam_wins;

`ifdef MEM_ARB_RR_EN
  logic [2:0] starve_q, starve_d;

  assign cam_force = cam_req_i && ({29'd0, starve_q} == STARVE_LIM);

  // Counts IDLE cycles the camera lost to the CPU; a grant clears it.
  always_comb begin
    starve_d = starve_q;
    if (state_q == CAM_WR) begin
      starve_d = 3'd0;
    end else if ((state_q == IDLE) && cam_req_i && cpu_wins && (starve_q != 3'd7)) begin
      starve_d = starve_q + 3'd1;
    end
  end
`else
  assign cam_force = 1'b0;
`endif

  // Next state and memory-port drive. mem_addr/mem_wdata fall back to the
  // last driven value so the port never shows X. While reset is asserted
  // nothing is driven and the stall simply mirrors the request.
  always_comb begin
    state_d     = state_q;
    mem_we_o    = 1'b0;
    mem_addr_o  = mem_addr_q;
    mem_wdata_o = mem_wdata_q;
    cpu_stall_o = cpu_req_i;
    cpu_wins    = 1'b0;
    cam_wins    = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          cpu_wins = cpu_req_i && !cam_force;
          cam_wins = cam_req_i && !cpu_wins;
          if (cpu_wins) begin
            mem_addr_o = cpu_addr_i;
            if (cpu_we_i) begin
              mem_we_o    = 1'b1;
              mem_wdata_o = cpu_wdata_i;
              cpu_stall_o = 1'b0;
            end else begin
              cpu_stall_o = 1'b1;
              state_d     = CPU_RD;
            end
          end else if (cam_wins) begin
            state_d = CAM_WR;
          end
        end
        CPU_RD: begin
          // Read data arrives this cycle, so the load is complete here.
          cpu_stall_o = 1'b0;
          state_d     = IDLE;
        end
        CAM_WR: begin
          mem_we_o    = 1'b1;
          mem_addr_o  = cam_addr_q;
          mem_wdata_o = cam_wdata_q;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cam_addr_q   <= 32'd0;
      cam_wdata_q  <= 32'd0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      cpu_rdata_q  <= 32'd0;
      cpu_rvalid_q <= 1'b0;
      cam_gnt_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      starve_q     <= 3'd0;
`endif
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_o;
      mem_wdata_q  <= mem_wdata_o;
      cam_gnt_q    <= (state_d == CAM_WR);
      cpu_rvalid_q <= (state_q == CPU_RD);
      if (state_q == CPU_RD) begin
        cpu_rdata_q <= mem_rdata_i;
      end
      if (cam_wins) begin
        cam_addr_q  <= cam_addr_i;
        cam_wdata_q <= cam_wdata_i;
      end
`ifdef MEM_ARB_RR_EN
      starve_q     <= starve_d;
`endif
    end
  end

  assign cpu_rdata_o  = cpu_rdata_q;
  assign cpu_rvalid_o = cpu_rvalid_q;
  assign cam_gnt_o    = cam_gnt_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed cycle checks for store, load, camera write, simultaneous requests,
// reset during a load and the starvation pattern, followed by randomized
// CPU/camera traffic. Expected store/write/load values are queued when a
// request is issued; a negedge monitor pops them as the DUT presents writes
// and load data. The CPU view of memory is a simple address->data map
// updated in program order; camera writes go to a disjoint address region.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int CPU_TMO = 20;
  localparam int CAM_TMO = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        cam_req;
  logic [31:0] cam_addr, cam_wdata;
  logic        cam_gnt;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  state_o;

  int errors = 0;
  int checks = 0;
  int gnt_seen = 0;

  logic [63:0] cpu_wr_q[$];
  logic [63:0] cam_q[$];
  logic [31:0] rd_exp_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] stub[logic [31:0]];

  mem_port_arbiter #(.STARVE_LIM(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cpu_req_i    (cpu_req),
    .cpu_we_i     (cpu_we),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_stall_o  (cpu_stall),
    .cpu_rdata_o  (cpu_rdata),
    .cpu_rvalid_o (cpu_rvalid),
    .cam_req_i    (cam_req),
    .cam_addr_i   (cam_addr),
    .cam_wdata_i  (cam_wdata),
    .cam_gnt_o    (cam_gnt),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .state_o      (state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Content of never-written locations; 0x200 holds the directed load value.
  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a == 32'h0000_0200) return 32'h1234_5678;
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_0F0F;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  // Data memory with one-cycle synchronous read.
  always @(posedge clk) begin
    if (mem_we) stub[mem_addr] = mem_wdata;
    mem_rdata <= stub.exists(mem_addr) ? stub[mem_addr] : init_val(mem_addr);
  end

  // ---------------- checking helpers ----------------
  task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        if (cam_gnt) begin
          gnt_seen++;
          check_b("cam_gnt_mem_we", mem_we, 1'b1);
          check_b("cam_wr_stall", cpu_stall, cpu_req);
          if (cam_q.size() == 0) fail_event("cam_gnt_unexpected");
          else begin
            e = cam_q.pop_front();
            check_w("cam_wr_addr", mem_addr, e[63:32]);
            check_w("cam_wr_data", mem_wdata, e[31:0]);
          end
        end else if (mem_we) begin
          if (cpu_wr_q.size() == 0) fail_event("cpu_store_unexpected");
          else begin
            e = cpu_wr_q.pop_front();
            check_w("cpu_st_addr", mem_addr, e[63:32]);
            check_w("cpu_st_data", mem_wdata, e[31:0]);
          end
        end
        if (cpu_rvalid) begin
          if (rd_exp_q.size() == 0) fail_event("cpu_rvalid_unexpected");
          else check_w("cpu_ld_data", cpu_rdata, rd_exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the rising edge that
  // closes the completing cycle. waited = stalled cycles before completion.
  task automatic cpu_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                            output int waited);
    waited    = 0;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    if (we) begin
      cpu_wr_q.push_back({a, d});
      ref_mem[a] = d;
    end else begin
      rd_exp_q.push_back(ref_read(a));
    end
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      waited++;
      if (waited > CPU_TMO) begin
        fail_event("cpu_stall_timeout");
        break;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic cam_write(input logic [31:0] a, input logic [31:0] d);
    int waited;
    waited    = 0;
    cam_req   = 1'b1;
    cam_addr  = a;
    cam_wdata = d;
    cam_q.push_back({a, d});
    forever begin
      @(negedge clk);
      if (cam_gnt) break;
      waited++;
      if (waited > CAM_TMO) begin
        fail_event("cam_gnt_timeout");
        void'(cam_q.pop_back());
        break;
      end
    end
    @(posedge clk); #1;
    cam_req = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int w;
    int cycles;
    int g0;
    int g_cpu;
    logic cpu_done;

    // Reset with requests pending: nothing may reach the memory port.
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hDEAD_BEE0; cpu_wdata = 32'h0;
    cam_req = 1'b1; cam_addr = 32'h8000_0000; cam_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check_w("rst_state", 32'(state_o), 32'd0);
    check_b("rst_mem_we", mem_we, 1'b0);
    check_w("rst_mem_addr", mem_addr, 32'd0);
    check_w("rst_mem_wdata", mem_wdata, 32'd0);
    check_b("rst_rvalid", cpu_rvalid, 1'b0);
    check_w("rst_rdata", cpu_rdata, 32'd0);
    check_b("rst_cam_gnt", cam_gnt, 1'b0);
    check_b("rst_stall_follows_req", cpu_stall, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0; cpu_req = 1'b0; cam_req = 1'b0;
    @(negedge clk);
    check_b("idle_stall", cpu_stall, 1'b0);
    check_b("idle_mem_we", mem_we, 1'b0);
    check_b("idle_cam_gnt", cam_gnt, 1'b0);
    next_cycle();

    // Store completes in the request cycle.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'hCAFE_0001;
    cpu_wr_q.push_back({32'h100, 32'hCAFE_0001});
    ref_mem[32'h100] = 32'hCAFE_0001;
    @(negedge clk);
    check_b("st_mem_we", mem_we, 1'b1);
    check_w("st_mem_addr", mem_addr, 32'h100);
    check_w("st_mem_wdata", mem_wdata, 32'hCAFE_0001);
    check_b("st_stall", cpu_stall, 1'b0);
    next_cycle();
    cpu_req = 1'b0;

    // Load: stall, then release, then rvalid.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200;
    rd_exp_q.push_back(ref_read(32'h200));
    @(negedge clk);
    check_b("ld_c1_stall", cpu_stall, 1'b1);
    check_w("ld_c1_mem_addr", mem_addr, 32'h200);
    check_b("ld_c1_mem_we", mem_we, 1'b0);
    next_cycle();
    @(negedge clk);
    check_b("ld_c2_stall", cpu_stall, 1'b0);
    check_w("ld_c2_state", 32'(state_o), 32'd1);
    check_b("ld_c2_rvalid", cpu_rvalid, 1'b0);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    check_b("ld_c3_rvalid", cpu_rvalid, 1'b1);
    check_w("ld_c3_rdata", cpu_rdata, 32'h1234_5678);
    next_cycle();
    @(negedge clk);
    check_b("ld_c4_rvalid_pulse", cpu_rvalid, 1'b0);
    next_cycle();

    // Camera-only write.
    cam_req = 1'b1; cam_addr = 32'h8000; cam_wdata = 32'h00FF_00FF;
    cam_q.push_back({32'h8000, 32'h00FF_00FF});
    @(negedge clk);
    check_b("cam_c1_gnt", cam_gnt, 1'b0);
    check_b("cam_c1_stall", cpu_stall, 1'b0);
    next_cycle();
    @(negedge clk);
    check_b("cam_c2_gnt", cam_gnt, 1'b1);
    check_b("cam_c2_mem_we", mem_we, 1'b1);
    check_w("cam_c2_mem_addr", mem_addr, 32'h8000);
    check_w("cam_c2_mem_wdata", mem_wdata, 32'h00FF_00FF);
    next_cycle();
    cam_req = 1'b0;
    @(negedge clk);
    check_b("cam_c3_gnt", cam_gnt, 1'b0);
    check_b("cam_c3_mem_we", mem_we, 1'b0);
    check_w("cam_c3_addr_hold", mem_addr, 32'h8000);
    next_cycle();

    // Simultaneous load and camera: CPU first, camera after return to IDLE.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    rd_exp_q.push_back(ref_read(32'h40));
    cam_req = 1'b1; cam_addr = 32'h8010; cam_wdata = 32'hA5A5_0F0F;
    cam_q.push_back({32'h8010, 32'hA5A5_0F0F});
    @(negedge clk);
    check_b("sim_c1_stall", cpu_stall, 1'b1);
    check_b("sim_c1_gnt", cam_gnt, 1'b0);
    next_cycle();
    @(negedge clk);
    check_w("sim_c2_state", 32'(state_o), 32'd1);
    check_b("sim_c2_gnt", cam_gnt, 1'b0);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    check_b("sim_c3_rvalid", cpu_rvalid, 1'b1);
    check_b("sim_c3_gnt", cam_gnt, 1'b0);
    next_cycle();
    @(negedge clk);
    check_b("sim_c4_gnt", cam_gnt, 1'b1);
    next_cycle();
    cam_req = 1'b0;

    // Reset in the middle of CPU_RD abandons the load.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44;
    rd_exp_q.push_back(ref_read(32'h44));
    next_cycle();
    #2 rst = 1'b1;
    @(negedge clk);
    check_w("rrd_state", 32'(state_o), 32'd0);
    check_b("rrd_stall", cpu_stall, 1'b1);
    check_b("rrd_rvalid", cpu_rvalid, 1'b0);
    check_w("rrd_rdata", cpu_rdata, 32'd0);
    check_w("rrd_mem_addr", mem_addr, 32'd0);
    check_b("rrd_mem_we", mem_we, 1'b0);
    void'(rd_exp_q.pop_back());
    next_cycle();
    rst = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    check_b("rrd_after1_rvalid", cpu_rvalid, 1'b0);
    check_w("rrd_after1_state", 32'(state_o), 32'd0);
    next_cycle();
    @(negedge clk);
    check_b("rrd_after2_rvalid", cpu_rvalid, 1'b0);
    next_cycle();
    cpu_access(1'b0, 32'h44, 32'd0, w);
    check_w("reissue_wait", 32'(w), 32'd1);
    repeat (2) next_cycle();

    // Continuous stores against a continuous camera request.
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    cycles = 0;
    g0 = gnt_seen;
`ifdef MEM_ARB_RR_EN
    cpu_done = 1'b0;
    g_cpu = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          cpu_access(1'b1, 32'(i * 4), $urandom, w);
          cycles += w + 1;
        end
        g_cpu = gnt_seen - g0;
        cpu_done = 1'b1;
      end
      begin
        int k;
        k = 0;
        while (!cpu_done) begin
          cam_write(32'h9000 + 32'(k * 4), $urandom);
          k++;
        end
      end
    join
    check_w("starve_cycles", 32'(cycles), 32'd22);
    check_w("starve_grants", 32'(g_cpu), 32'd3);
`else
    cpu_done = 1'b0;
    cam_req = 1'b1; cam_addr = 32'h9000; cam_wdata = 32'h1111_2222;
    for (int i = 0; i < 16; i++) begin
      cpu_access(1'b1, 32'(i * 4), $urandom, w);
      cycles += w + 1;
    end
    cpu_done = 1'b1;
    g_cpu = gnt_seen - g0;
    cam_req = 1'b0;
    check_w("starve_cycles", 32'(cycles), 32'd16);
    check_w("starve_grants", 32'(g_cpu), 32'd0);
`endif
    check_b("starve_done", cpu_done, 1'b1);
    repeat (2) next_cycle();

    // Randomized mixed traffic.
    fork
      begin
        for (int i = 0; i < 120; i++) begin
          repeat ($urandom_range(0, 3)) next_cycle();
          cpu_access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 31) * 4), $urandom, w);
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 6)) next_cycle();
          cam_write(32'h8000 + 32'($urandom_range(0, 255) * 4), $urandom);
        end
      end
    join
    repeat (4) next_cycle();

    check_w("end_cpu_wr_q", 32'(cpu_wr_q.size()), 32'd0);
    check_w("end_cam_q", 32'(cam_q.size()), 32'd0);
    check_w("end_rd_exp_q", 32'(rd_exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
